// File: rtl/shared_acc_if.sv
// shared_acc_if: requester-side handshake bundle for the shared accumulator arbiter
interface shared_acc_if #(parameter int NREQ = 4, parameter int DW = 8);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] lock;
  logic [2*NREQ-1:0] op;
  logic [DW*NREQ-1:0] wdata;
  logic [NREQ-1:0] gnt;
  logic busy;
  logic [DW-1:0] acc;
  modport master(output req, lock, op, wdata, input gnt, busy, acc);
  modport slave(input req, lock, op, wdata, output gnt, busy, acc);
endinterface

// File: rtl/shared_acc_arbiter.sv
// shared_acc_arbiter: round-robin arbiter giving one requester at a time write access to a shared accumulator
module shared_acc_arbiter #(
  parameter int NREQ = 4,
  parameter int DW = 8,
  parameter int MAXBURST = 4
) (
  input logic clk,
  input logic rst,
  shared_acc_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(MAXBURST + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [NREQ-1:0] gnt, gnt_n;
  logic [PW-1:0] ptr, ptr_n, w, w_n, win;
  logic [BW-1:0] beat_cnt, beat_cnt_n;
  logic [DW-1:0] acc, acc_n, wd;
  logic [1:0] wop;
  logic beat, stay;
  // descending scan so the requester closest to ptr is the last (winning) assignment
  always_comb begin
    win = ptr;
    for (int i = NREQ - 1; i >= 0; i--)
      if (bus.req[(int'(ptr) + i) % NREQ]) win = PW'((int'(ptr) + i) % NREQ);
  end
  assign wop = bus.op[2*int'(w) +: 2];
  assign wd = bus.wdata[DW*int'(w) +: DW];
  assign beat = state == GRANT && bus.req[w];
  assign stay = beat && bus.lock[w] && int'(beat_cnt) + 1 < MAXBURST;
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    ptr_n = ptr;
    w_n = w;
    beat_cnt_n = beat_cnt;
    acc_n = acc;
    if (state == IDLE) begin
      if (|bus.req) begin
        state_n = GRANT;
        gnt_n = NREQ'(1) << win;
        w_n = win;
        beat_cnt_n = '0;
      end
    end else begin
      if (beat) begin
        acc_n = wop == 2'b00 ? wd : wop == 2'b01 ? acc ^ wd : wop == 2'b10 ? acc | wd : acc & wd;
        beat_cnt_n = beat_cnt + 1'b1;
      end
      if (!stay) begin
        state_n = IDLE;
        gnt_n = '0;
        ptr_n = PW'((int'(w) + 1) % NREQ);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      ptr <= '0;
      w <= '0;
      beat_cnt <= '0;
      acc <= '0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      ptr <= ptr_n;
      w <= w_n;
      beat_cnt <= beat_cnt_n;
      acc <= acc_n;
    end
  end
  assign bus.gnt = gnt;
  assign bus.busy = state == GRANT;
  assign bus.acc = acc;
endmodule

// File: doc/shared_acc_arbiter.md
# shared_acc_arbiter

Round-robin arbiter that gives NREQ requesters exclusive, sequenced write access to one shared accumulator register. It enforces a single-writer discipline on that variable: only the granted requester's data and opcode reach the accumulator, so no two processes ever drive it. Each requester supplies an operand and a reduce opcode (load/XOR/OR/AND), and may lock the grant for a bounded burst. The block sits between requester processes and any logic that consumes the accumulated result.

## Interface
- NREQ, 4: number of requesters; 2 to 16.
- DW, 8: operand and accumulator width.
- MAXBURST, 4: maximum beats per grant while locked; 1 to 255.
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- req  in  NREQ  per-requester valid; held until accepted.
- lock  in  NREQ  per-requester burst request; sampled only while that requester is granted.
- op  in  2*NREQ  opcode of requester i in op[2i+1:2i]: 00 LOAD, 01 XOR, 10 OR, 11 AND.
- wdata  in  DW*NREQ  operand of requester i in wdata[DW*i+DW-1:DW*i].
- gnt  out  NREQ  one-hot registered grant; all zero when idle.
- busy  out  1  high while in GRANT.
- acc  out  DW  shared accumulator, registered.

## Operation
- States: IDLE, GRANT. Pointer ptr, width clog2(NREQ), gives the highest-priority index. Owner w is registered. beat_cnt is a counter of width clog2(MAXBURST+1).
- IDLE: if any req is high, the winner is the first set req at or after ptr, searching upward modulo NREQ. Next state is GRANT, with gnt set to onehot(winner), w set to winner, and beat_cnt set to 0. If no req is high, stay in IDLE with gnt all zero.
- GRANT beat: a cycle with gnt[w] and req[w] both high. On a beat, acc is updated from op[w] and wdata[w]:
  - LOAD: acc = wdata.
  - XOR: acc = acc ^ wdata.
  - OR: acc = acc | wdata.
  - AND: acc = acc & wdata.
  - beat_cnt increments on every beat.
- Stay in GRANT after a beat only if lock[w] is high and beat_cnt+1 < MAXBURST. Otherwise the grant is released: next state IDLE, gnt set to 0, and ptr set to (w+1) mod NREQ.
- req[w] low while in GRANT is a protocol violation, but it is tolerated. No write occurs, the grant is released, and ptr advances past w.
- Requesters not granted are ignored. Their op, wdata and lock are don't-care.
- Only this block writes acc. No other path modifies it.
- Reset: state IDLE, gnt = 0, busy = 0, acc = 0, ptr = 0, beat_cnt = 0.

## Timing
- Grant latency: req sampled high in IDLE at edge N gives gnt high in cycle N+1.
- Commit: a beat in cycle k updates acc at the end of k, so the new value is visible in k+1.
- Release: there is always exactly one IDLE bubble cycle after a grant ends.
  - Unlocked throughput is one beat per 2 cycles.
  - A locked burst delivers up to MAXBURST beats on consecutive cycles.
- Requester handshake: treat gnt&req as "accepted this cycle". The requester presents the next operand, or drops req, in the following cycle. A req still high after release is a new request, not a stale one.
- Fairness: a released owner has the lowest priority in the next arbitration. With all NREQ requesting continuously, each waits at most (NREQ-1)*(MAXBURST+1) cycles.
- Burst cap: a lock still held at beat MAXBURST does not extend the grant. The release happens anyway and ptr advances.
- Lock dropping mid-burst: the beat in which lock is low is the last beat.
- rst asserted in any state, including mid-burst, takes priority over a concurrent beat. That beat is not written, and the next cycle shows the reset values.
- gnt, busy and acc are pure register outputs with no combinational path from inputs.

## Test plan
- Reset: rst high for 2 cycles with random req/op/wdata. Required: gnt=0, busy=0, acc=0x00 throughout and on the first cycle after rst falls.
- Single LOAD: req[0]=1, op0=LOAD, wdata0=0xA5, sampled at edge 1. Required:
  - gnt=0001 in cycle 2.
  - acc=0xA5 and gnt=0000 in cycle 3.
  - req[0] dropped in cycle 3 leaves the block idle.
- Round robin: all req held high, no lock, op=XOR, wdata = 0x01/0x02/0x04/0x08, acc starting at 0. Required:
  - Grant order is 0,1,2,3,0, each 2 cycles apart.
  - acc reads 0x01, 0x03, 0x07, 0x0F after successive grants.
- Burst cap (MAXBURST=4): req[1] and lock[1] high, offering 6 XOR beats of 0x11, with req[2] also pending. Required:
  - gnt=0010 for exactly 4 consecutive cycles, and acc=0x00 at the end.
  - One IDLE cycle, then gnt=0100 before requester 1 is re-granted.
- Reset mid-burst: rst asserted during beat 2 of a locked burst by requester 3. Required:
  - The next cycle shows gnt=0, acc=0, busy=0.
  - The next arbitration with all requesting grants requester 0.
- Dropped req: req[2] falls in its GRANT cycle. Required:
  - acc is unchanged and the next cycle is IDLE.
  - ptr=3, so with req[0] and req[3] both high, requester 3 wins.
